// File: rtl/drum_pkg.sv
// Shared widths and types for the DRUM approximate multiplier.
package drum_pkg;

    localparam int N_W  = 4;
    localparam int K_W  = 3;
    localparam int P_W  = 2 * N_W;
    localparam int SH_W = $clog2(N_W - K_W + 2);

    typedef logic [N_W-1:0]  operand_t;
    typedef logic [K_W-1:0]  frag_t;
    typedef logic [SH_W-1:0] shift_t;
    typedef logic [P_W-1:0]  prod_t;

endpackage

// File: rtl/drum_lod.sv
// Leading-one detector and truncator: reduces one operand to a K-bit
// fragment plus the left shift that restores its magnitude.
module drum_lod
    import drum_pkg::*;
(
    input  logic [N_W-1:0]  x,
    output logic [K_W-1:0]  f,
    output logic [SH_W-1:0] s
);

    logic [$clog2(N_W)-1:0] lead;
    operand_t               shifted;

    always_comb begin
        lead = '0;
        for (int i = 0; i < N_W; i++) begin
            if (x[i]) begin
                lead = i[$clog2(N_W)-1:0];
            end
        end
    end

    // Small operands pass through exactly; larger ones keep the top K bits
    // and force the LSB high so truncation error averages out.
    always_comb begin
        s       = '0;
        shifted = x;
        f       = x[K_W-1:0];
        if (int'(lead) >= K_W) begin
            s       = shift_t'(int'(lead) - K_W + 1);
            shifted = x >> s;
            f       = shifted[K_W-1:0] | frag_t'(1);
        end
    end

endmodule

// File: rtl/drum_goekce.sv
// Tiny Tapeout top for a 4x4 DRUM approximate multiplier.
// Define DRUM_OUTREG_EN to register uo_out (1-cycle latency, async clear).
module drum_goekce
    import drum_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    frag_t       frag_a;
    frag_t       frag_b;
    shift_t      shift_a;
    shift_t      shift_b;
    logic [SH_W:0] shift_sum;
    prod_t       product;

    drum_lod lod_a (
        .x (ui_in[N_W-1:0]),
        .f (frag_a),
        .s (shift_a)
    );

    drum_lod lod_b (
        .x (ui_in[2*N_W-1:N_W]),
        .f (frag_b),
        .s (shift_b)
    );

    // Each fragment shifted back stays below 2^N, so the product fits P_W bits.
    always_comb begin
        shift_sum = {1'b0, shift_a} + {1'b0, shift_b};
        product   = (prod_t'(frag_a) * prod_t'(frag_b)) << shift_sum;
    end

    assign uio_out = '0;
    assign uio_oe  = '0;

`ifdef DRUM_OUTREG_EN
    logic unused;
    assign unused = &{1'b0, ena, uio_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uo_out <= '0;
        end else begin
            uo_out <= product;
        end
    end
`else
    logic unused;
    assign unused = &{1'b0, ena, uio_in, clk, rst_n};

    assign uo_out = product;
`endif

endmodule

// File: tb/tb_drum_goekce.sv
// Self-checking bench for drum_goekce, valid with or without DRUM_OUTREG_EN.
module tb_drum_goekce;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int error_count = 0;
    int check_count = 0;

    logic [7:0] exp_q[$];

    drum_goekce dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: repeatedly halve an operand until it fits in K bits.
    function automatic int reduce(input int x, output int sh);
        int t;
        t  = x;
        sh = 0;
        if (t >= 8) begin
            while (t >= 8) begin
                t  = t / 2;
                sh = sh + 1;
            end
            t = t | 1;
        end
        return t;
    endfunction

    function automatic logic [7:0] drum_model(input logic [7:0] v);
        int fa, fb, sa, sb, r;
        fa = reduce(int'(v[3:0]), sa);
        fb = reduce(int'(v[7:4]), sb);
        r  = (fa * fb) * (1 << (sa + sb));
        return r[7:0];
    endfunction

    task automatic drive(input logic [7:0] v);
        @(negedge clk);
        ui_in = v;
        exp_q.push_back(drum_model(v));
    endtask

    task automatic sample(output logic [7:0] got);
        @(posedge clk);
        #1;
        got = uo_out;
    endtask

    task automatic test_reset();
        logic [7:0] expected;
        rst_n  = 1'b0;
        ena    = 1'b1;
        uio_in = 8'h00;
        ui_in  = 8'hFF;
        #3;
`ifdef DRUM_OUTREG_EN
        expected = 8'd0;
`else
        expected = 8'd196;
`endif
        check_count++;
        if (uo_out !== expected) begin
            error_count++;
            $display("[TB] FAIL reset_uo_out got=%0d want=%0d", uo_out, expected);
        end
        @(posedge clk);
        #1;
        check_count++;
        if (uo_out !== expected) begin
            error_count++;
            $display("[TB] FAIL reset_after_edge got=%0d want=%0d", uo_out, expected);
        end
        check_count++;
        if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            error_count++;
            $display("[TB] FAIL reset_tieoff uio_out=%h uio_oe=%h want=00/00", uio_out, uio_oe);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [7:0] vectors [9];
        logic [7:0] want    [9];
        logic [7:0] got;
        logic [7:0] e;
        vectors = '{8'h23, 8'h21, 8'hF0, 8'h0F, 8'h77, 8'hFF, 8'h98, 8'h5C, 8'h00};
        want    = '{8'd6, 8'd2, 8'd0, 8'd0, 8'd49, 8'd196, 8'd100, 8'd70, 8'd0};
        for (int i = 0; i < 9; i++) begin
            drive(vectors[i]);
            sample(got);
            e = exp_q.pop_front();
            check_count++;
            if (got !== e) begin
                error_count++;
                $display("[TB] FAIL directed_model ui_in=%h got=%0d want=%0d", vectors[i], got, e);
            end
            check_count++;
            if (got !== want[i]) begin
                error_count++;
                $display("[TB] FAIL directed_const ui_in=%h got=%0d want=%0d", vectors[i], got, want[i]);
            end
        end
    endtask

    task automatic test_sweep();
        logic [7:0] got;
        logic [7:0] e;
        for (int v = 0; v < 256; v++) begin
            drive(v[7:0]);
            ena    = $urandom_range(0, 1) == 1;
            uio_in = 8'($urandom);
            sample(got);
            e = exp_q.pop_front();
            check_count++;
            if (got !== e) begin
                error_count++;
                $display("[TB] FAIL sweep ui_in=%h got=%0d want=%0d", v[7:0], got, e);
            end
            check_count++;
            if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
                error_count++;
                $display("[TB] FAIL sweep_tieoff uio_out=%h uio_oe=%h want=00/00", uio_out, uio_oe);
            end
        end
    endtask

    task automatic test_ignored_inputs();
        logic [7:0] got;
        logic [7:0] e;
        for (int i = 0; i < 8; i++) begin
            drive(8'h5C);
            ena    = i[0];
            uio_in = 8'(i * 37 + 1);
            sample(got);
            e = exp_q.pop_front();
            check_count++;
            if (got !== e) begin
                error_count++;
                $display("[TB] FAIL ignored_inputs ena=%b uio_in=%h got=%0d want=%0d", ena, uio_in, got, e);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] got;
        logic [7:0] e;
        logic [7:0] expected;
        drive(8'h23);
        sample(got);
        e = exp_q.pop_front();
        check_count++;
        if (got !== e) begin
            error_count++;
            $display("[TB] FAIL pre_reset got=%0d want=%0d", got, e);
        end
        #1;
        rst_n = 1'b0;
        #1;
`ifdef DRUM_OUTREG_EN
        expected = 8'd0;
`else
        expected = 8'd6;
`endif
        check_count++;
        if (uo_out !== expected) begin
            error_count++;
            $display("[TB] FAIL mid_reset_async got=%0d want=%0d", uo_out, expected);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'hFF);
        sample(got);
        e = exp_q.pop_front();
        check_count++;
        if (got !== e) begin
            error_count++;
            $display("[TB] FAIL post_reset_capture got=%0d want=%0d", got, e);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_sweep();
        test_ignored_inputs();
        test_mid_reset();
        check_count++;
        if (exp_q.size() != 0) begin
            error_count++;
            $display("[TB] FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule

// File: doc/drum_goekce.md
Name: drum_goekce

Overview:
- Tiny Tapeout user-project top implementing a DRUM (Dynamic Range Unbiased Multiplier) approximate unsigned multiplier.
- Two N-bit operands arrive packed on the dedicated inputs; the 2N-bit approximate product drives the dedicated outputs.
- Bidirectional pins are unused.
- Default build is purely combinational. The clock and reset only matter when the optional output register is compiled in.

Parameters:
- N, 4, operand width in bits; 2N must equal 8 (uo_out width).
- K, 3, DRUM fragment width in bits; legal range 2..N. K = N gives an exact multiplier.

Ports:
- clk  input  1  system clock; used only with DRUM_OUTREG_EN.
- rst_n  input  1  reset, asynchronous, active-low; used only with DRUM_OUTREG_EN.
- ena  input  1  design-selected flag; ignored.
- ui_in  input  8  ui_in[3:0] = operand a, ui_in[7:4] = operand b (unsigned).
- uo_out  output  8  approximate product r of a and b (unsigned).
- uio_in  input  8  ignored.
- uio_out  output  8  tied to 0.
- uio_oe  output  8  tied to 0 (all bidirectional pins are inputs).

Behaviour:
- Per operand x (N bits):
  - If x < 2^K: fragment f = x, shift s = 0. These operands are used exactly.
  - Otherwise: let p = index of the leading one of x.
    - s = p-K+1.
    - f = x[p:p-K+1], with f[0] forced to 1 (unbiasing).
- Product: r = (fa * fb) << (sa + sb), computed at 2N bits.
  - Overflow cannot occur, because f << s < 2^(p+1) ≤ 2^N for each operand.
- Zero operand gives r = 0; no special casing is needed.
- Product is exact whenever both operands are < 2^K.
- Default build:
  - uo_out is combinational from ui_in and must settle within the same evaluation.
  - No state; clk and rst_n have no effect.
- ena and uio_in never affect any output.

Optional Feature:
- Macro name: DRUM_OUTREG_EN.
- Defined:
  - uo_out comes from an 8-bit register loaded with r on every rising clk edge; latency is 1 cycle.
  - rst_n low asynchronously clears the register to 0, including mid-operation.
  - The register captures normally on the first rising edge after rst_n deasserts.
- Undefined:
  - Combinational path as described above; no flops in the design.

Decomposition:
- Package drum_pkg:
  - Localparams N_W = 4, K_W = 3, P_W = 2*N_W.
  - Typedefs for the operand, fragment, shift-amount (clog2(N_W-K_W+2) bits) and product types.
- Sub-module drum_lod, instantiated once per operand:
  - Leading-one detector plus truncator.
  - Input x[N-1:0]; outputs f[K-1:0] and s.
  - Implements the fragment/shift rules above.
- Top level contains the K×K multiply, the shift, pin packing, the tie-offs and the optional register.

Test Plan:
- a=3, b=2 (ui_in=0x23) -> uo_out=6; a=1, b=2 (ui_in=0x21) -> uo_out=2 (exact region).
- a=0, b=15 and a=15, b=0 -> uo_out=0; a=7, b=7 -> 49 (exact).
- a=15, b=15 -> fragments 7/7, shift 1+1 -> uo_out=196. a=8, b=9 -> fragments 5/5, shift 2 -> uo_out=100.
- a=12, b=5 -> fa=7 (s=1), fb=5 (s=0) -> uo_out=70.
- Exhaustive sweep of all 256 ui_in values against a behavioural DRUM model. Also check that uio_out=0 and uio_oe=0 always, and that toggling ena or uio_in has no effect.
- With DRUM_OUTREG_EN defined:
  - rst_n=0 -> uo_out=0 regardless of ui_in or clk.
  - After release, with ui_in=0x23: uo_out=6 one clk edge later.
  - Asserting rst_n mid-stream clears uo_out immediately, without waiting for a clock edge.
